// File: rtl/fp_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp_iter_divider
// Description : Sequential floating-point divider Q = A / B. Operands use a
//               signed unbiased exponent and an explicit-leading-one mantissa.
//               Restoring division, one quotient bit per cycle, with a
//               start/busy/done handshake. Fixed latency for every operand.
// Build option: FPDIV_ROUND_EN - defined: round-to-nearest-even,
//               undefined: truncate.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_iter_divider #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EXP_W-1:0] expA,
    input  logic [MAN_W-1:0] manA,
    input  logic [EXP_W-1:0] expB,
    input  logic [MAN_W-1:0] manB,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] expQ,
    output logic [MAN_W-1:0] manQ,
    output logic             div_by_zero,
    output logic             ovf,
    output logic             unf
);

    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam int E_W   = EXP_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]      C_CNT_LAST = CNT_W'(MAN_W + 1);
    localparam logic signed [E_W-1:0] C_E_MAX    = E_W'(2**(EXP_W-1) - 1);
    localparam logic signed [E_W-1:0] C_E_MIN    = E_W'(-(2**(EXP_W-1)));
    localparam logic signed [E_W-1:0] C_E_ONE    = E_W'(1);
    localparam logic [EXP_W-1:0]      C_INF_EXP  = EXP_W'(2**(EXP_W-1) - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [MAN_W:0]          r_rem;
    logic [MAN_W:0]          w_diff;
    logic [MAN_W:0]          w_rem_nxt;
    logic [MAN_W+1:0]        r_q;
    logic [EXP_W-1:0]        r_exp_a;
    logic [EXP_W-1:0]        r_exp_b;
    logic [MAN_W-1:0]        r_man_b;
    logic                    r_a_zero;
    logic                    w_ge;
    logic signed [E_W-1:0]   w_e_diff;
    logic signed [E_W-1:0]   w_e;
    logic [MAN_W-1:0]        w_man;
    logic [EXP_W-1:0]        w_exp_q;
    logic [MAN_W-1:0]        w_man_q;
    logic                    w_dbz;
    logic                    w_ovf;
    logic                    w_unf;
`ifdef FPDIV_ROUND_EN
    logic                    w_guard;
    logic                    w_sticky;
    logic [MAN_W:0]          w_man_inc;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == C_CNT_LAST) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_DONE;
            S_DONE:  begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One restoring step. The compare precedes the shift so the first
    // quotient bit carries integer weight (A/B lies in (0.5, 2)); the stored
    // remainder stays below 2*manB and fits MAN_W+1 bits.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_man_b});
        w_diff    = w_ge ? (r_rem - {1'b0, r_man_b}) : r_rem;
        w_rem_nxt = w_diff << 1;
    end

    // Normalize the quotient and optionally round; exponent kept wide so
    // out-of-range results are detected rather than wrapped.
    always_comb begin
        w_e_diff = $signed({{2{r_exp_a[EXP_W-1]}}, r_exp_a})
                 - $signed({{2{r_exp_b[EXP_W-1]}}, r_exp_b});
        w_e      = w_e_diff;
        w_man    = '0;
`ifdef FPDIV_ROUND_EN
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        w_man_inc = '0;
`endif
        if (r_q[MAN_W+1]) begin
            w_man    = r_q[MAN_W+1:2];
`ifdef FPDIV_ROUND_EN
            w_guard  = r_q[1];
            w_sticky = r_q[0] | (r_rem != '0);
`endif
        end else begin
            w_man    = r_q[MAN_W:1];
            w_e      = w_e_diff - C_E_ONE;
`ifdef FPDIV_ROUND_EN
            w_guard  = r_q[0];
            w_sticky = (r_rem != '0);
`endif
        end
`ifdef FPDIV_ROUND_EN
        w_man_inc = {1'b0, w_man} + (MAN_W+1)'(1);
        if (w_guard & (w_sticky | w_man[0])) begin
            if (w_man_inc[MAN_W]) begin
                w_man = {1'b1, {(MAN_W-1){1'b0}}};
                w_e   = w_e + C_E_ONE;
            end else begin
                w_man = w_man_inc[MAN_W-1:0];
            end
        end
`endif
    end

    // Special cases and range checks, highest priority first.
    always_comb begin
        w_exp_q = w_e[EXP_W-1:0];
        w_man_q = w_man;
        w_dbz   = 1'b0;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        if (r_man_b == '0) begin
            w_exp_q = C_INF_EXP;
            w_man_q = '0;
            w_dbz   = 1'b1;
        end else if (r_a_zero) begin
            w_exp_q = '0;
            w_man_q = '0;
        end else if (w_e > C_E_MAX) begin
            w_exp_q = C_INF_EXP;
            w_man_q = '0;
            w_ovf   = 1'b1;
        end else if (w_e < C_E_MIN) begin
            w_exp_q = '0;
            w_man_q = '0;
            w_unf   = 1'b1;
        end
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_man_b     <= '0;
            r_a_zero    <= 1'b0;
            expQ        <= '0;
            manQ        <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_exp_a  <= expA;
                        r_exp_b  <= expB;
                        r_man_b  <= manB;
                        r_a_zero <= (manA == '0);
                        r_rem    <= {1'b0, manA};
                        r_q      <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[MAN_W:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    expQ        <= w_exp_q;
                    manQ        <= w_man_q;
                    div_by_zero <= w_dbz;
                    ovf         <= w_ovf;
                    unf         <= w_unf;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_iter_divider
// Description : Directed self-checking bench for fp_iter_divider with
//               hand-computed expected quotients, latency, handshake and
//               asynchronous reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_iter_divider;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [EXP_W-1:0] expA  = '0;
    logic [MAN_W-1:0] manA  = '0;
    logic [EXP_W-1:0] expB  = '0;
    logic [MAN_W-1:0] manB  = '0;
    logic             busy;
    logic             done;
    logic [EXP_W-1:0] expQ;
    logic [MAN_W-1:0] manQ;
    logic             div_by_zero;
    logic             ovf;
    logic             unf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_iter_divider #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .expA        (expA),
        .manA        (manA),
        .expB        (expB),
        .manB        (manB),
        .busy        (busy),
        .done        (done),
        .expQ        (expQ),
        .manQ        (manQ),
        .div_by_zero (div_by_zero),
        .ovf         (ovf),
        .unf         (unf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic launch(input logic [7:0] ea, input logic [23:0] ma,
                          input logic [7:0] eb, input logic [23:0] mb);
        expA  = ea;
        manA  = ma;
        expB  = eb;
        manB  = mb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts negedges after the sampling edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check_val("busy_after_start", {31'd0, busy}, 32'd1);
            if (done) break;
        end
        check_val("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_and_check(input string tag,
                                 input logic [7:0] ea, input logic [23:0] ma,
                                 input logic [7:0] eb, input logic [23:0] mb,
                                 input logic [7:0] exp_e, input logic [23:0] exp_m,
                                 input logic [2:0] exp_f);
        int lat;
        launch(ea, ma, eb, mb);
        wait_done(lat);
        check_val({tag, "_latency"}, lat, 32'd28);
        check_val({tag, "_expQ"}, {24'd0, expQ}, {24'd0, exp_e});
        check_val({tag, "_manQ"}, {8'd0, manQ}, {8'd0, exp_m});
        check_val({tag, "_flags"}, {29'd0, div_by_zero, ovf, unf}, {29'd0, exp_f});
        @(negedge clk);
        check_val({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int ndone;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check_val("rst_expQ", {24'd0, expQ}, 32'd0);
        check_val("rst_manQ", {8'd0, manQ}, 32'd0);
        check_val("rst_flags", {29'd0, div_by_zero, ovf, unf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic quotients
        run_and_check("t1", 8'h02, 24'h800000, 8'h00, 24'h800000, 8'h02, 24'h800000, 3'b000);
`ifdef FPDIV_ROUND_EN
        run_and_check("t2", 8'h00, 24'h800000, 8'h00, 24'hC00000, 8'hFF, 24'hAAAAAB, 3'b000);
        run_and_check("rnd", 8'h00, 24'h800000, 8'h00, 24'hFFFFFF, 8'hFF, 24'h800001, 3'b000);
`else
        run_and_check("t2", 8'h00, 24'h800000, 8'h00, 24'hC00000, 8'hFF, 24'hAAAAAA, 3'b000);
        run_and_check("rnd", 8'h00, 24'h800000, 8'h00, 24'hFFFFFF, 8'hFF, 24'h800000, 3'b000);
`endif
        run_and_check("one5", 8'h01, 24'hC00000, 8'h00, 24'h800000, 8'h01, 24'hC00000, 3'b000);

        // Special cases
        run_and_check("t3_dbz", 8'h05, 24'h900000, 8'h03, 24'h000000, 8'h7F, 24'h000000, 3'b100);
        run_and_check("t3_zero", 8'h05, 24'h000000, 8'h03, 24'h800000, 8'h00, 24'h000000, 3'b000);
        run_and_check("dbz_prio", 8'h05, 24'h000000, 8'h03, 24'h000000, 8'h7F, 24'h000000, 3'b100);

        // Exponent range
        run_and_check("t4_ovf", 8'h7F, 24'h800000, 8'h80, 24'h800000, 8'h7F, 24'h000000, 3'b010);
        run_and_check("t4_unf", 8'h80, 24'h800000, 8'h7F, 24'h800000, 8'h00, 24'h000000, 3'b001);
        run_and_check("emax", 8'h7F, 24'h800000, 8'h00, 24'h800000, 8'h7F, 24'h800000, 3'b000);
        run_and_check("emin", 8'h80, 24'h800000, 8'h00, 24'h800000, 8'h80, 24'h800000, 3'b000);
        run_and_check("emin_m1", 8'h80, 24'h800000, 8'h00, 24'hC00000, 8'h00, 24'h000000, 3'b001);

        // Outputs hold while idle
        repeat (5) @(negedge clk);
        check_val("hold_expQ", {24'd0, expQ}, 32'd0);
        check_val("hold_unf", {31'd0, unf}, 32'd1);

        // T5: start during DIV is ignored, single done, back-to-back start
        launch(8'h02, 24'h800000, 8'h00, 24'h800000);
        ndone = 0;
        lat   = 0;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            start = (i == 4);
            if (i == 4) begin
                expA = 8'h03;
                manA = 24'hC00000;
                expB = 8'h00;
                manB = 24'h800000;
            end
            if (done) begin
                ndone++;
                lat = i;
            end
        end
        start = 1'b0;
        check_val("t5_done_count", ndone, 32'd1);
        check_val("t5_latency", lat, 32'd28);
        check_val("t5_expQ", {24'd0, expQ}, 32'h02);
        check_val("t5_manQ", {8'd0, manQ}, 32'h800000);
        @(negedge clk);
        check_val("t5_busy_fall", {30'd0, busy, done}, 32'd0);
        launch(8'h03, 24'hC00000, 8'h00, 24'h800000);
        wait_done(lat);
        check_val("t5_b2b_latency", lat, 32'd28);
        check_val("t5_b2b_expQ", {24'd0, expQ}, 32'h03);
        check_val("t5_b2b_manQ", {8'd0, manQ}, 32'hC00000);
        @(negedge clk);

        // T6: asynchronous reset mid-divide
        launch(8'h01, 24'hC00000, 8'h00, 24'h800000);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_busy_done", {30'd0, busy, done}, 32'd0);
        check_val("t6_expQ", {24'd0, expQ}, 32'd0);
        check_val("t6_manQ", {8'd0, manQ}, 32'd0);
        check_val("t6_flags", {29'd0, div_by_zero, ovf, unf}, 32'd0);
        ndone = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_val("t6_no_done", ndone, 32'd0);
        check_val("t6_idle", {31'd0, busy}, 32'd0);
        run_and_check("t6_fresh", 8'h01, 24'hC00000, 8'h00, 24'h800000, 8'h01, 24'hC00000, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
